// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV32I instruction-decode pipeline stage between fetch and execute.
//   Decodes in_instr, drives the register-file read ports, and captures operand
//   values, the immediate and control fields into an ID/EX register. The
//   register sits behind a valid/ready handshake. The stage inserts load-use
//   bubbles and honours a pipeline flush.
//
// Parameters
//   XLEN     datapath width (only 32 is supported)
//   LU_BUBS  bubble cycles after a load before a dependent instruction (1..3)
//
// Ports
//   clk, rst                    clock; asynchronous active-low reset
//   in_valid/in_ready           fetch handshake, with in_instr and in_pc
//   flush                       kills the ID/EX contents (branch redirect)
//   rf_rs1/rf_rs2               register-file read addresses
//   rf_r1_en/rf_r2_en           read enables
//   rf_rs1_val/rf_rs2_val       read data, returned in the same cycle
//   out_valid/out_ready         execute handshake
//   out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_rd_wen,
//   out_alu_op, out_ctl         captured ID/EX fields
//                               out_ctl = {load, store, branch, jal, jalr, lui}
//   out_illegal                 present only when DECODE_ILLEGAL_TRAP_EN is defined
//
// Configuration macro
//   DECODE_ILLEGAL_TRAP_EN  When this macro is defined, an unsupported encoding
//                           sets out_illegal. In every build, such an encoding
//                           decodes as a NOP.
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LU_BUBS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    output logic            rf_r1_en,
    output logic            rf_r2_en,
    input  logic [XLEN-1:0] rf_rs1_val,
    input  logic [XLEN-1:0] rf_rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen,
    output logic [3:0]      out_alu_op,
    output logic [5:0]      out_ctl
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic            out_illegal
`endif
);

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    localparam logic [1:0] LU_BUBS_C = 2'(LU_BUBS);

    // Instruction fields
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc  = in_instr[6:0];
    assign f3   = in_instr[14:12];
    assign f7   = in_instr[31:25];
    assign rd_f = in_instr[11:7];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Decoded fields
    logic        dec_legal, dec_rs1, dec_rs2, dec_wr, dec_wen;
    logic [31:0] dec_imm;
    logic [3:0]  dec_alu;
    logic [5:0]  dec_ctl;

    always_comb begin
        dec_legal = 1'b1;
        dec_rs1   = 1'b0;
        dec_rs2   = 1'b0;
        dec_wr    = 1'b0;
        dec_imm   = '0;
        dec_alu   = '0;
        dec_ctl   = '0;
        case (opc)
            OPC_LUI: begin
                dec_wr  = 1'b1;
                dec_imm = imm_u;
                dec_ctl = 6'b000001;
            end
            OPC_AUIPC: begin
                dec_wr  = 1'b1;
                dec_imm = imm_u;
            end
            OPC_JAL: begin
                dec_wr  = 1'b1;
                dec_imm = imm_j;
                dec_ctl = 6'b000100;
            end
            OPC_JALR: begin
                dec_rs1 = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = imm_i;
                dec_ctl = 6'b000010;
            end
            OPC_BRANCH: begin
                dec_rs1 = 1'b1;
                dec_rs2 = 1'b1;
                dec_imm = imm_b;
                dec_alu = {1'b0, f3};
                dec_ctl = 6'b001000;
            end
            OPC_LOAD: begin
                dec_rs1 = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = imm_i;
                dec_ctl = 6'b100000;
            end
            OPC_STORE: begin
                dec_rs1 = 1'b1;
                dec_rs2 = 1'b1;
                dec_imm = imm_s;
                dec_ctl = 6'b010000;
            end
            OPC_OP_IMM: begin
                dec_rs1 = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = imm_i;
                dec_alu = {1'b0, f3};
                if (f3 == 3'b001) begin
                    dec_legal = (f7 == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    dec_legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    dec_alu   = {f7[5], f3};
                end
            end
            OPC_OP: begin
                dec_rs1   = 1'b1;
                dec_rs2   = 1'b1;
                dec_wr    = 1'b1;
                dec_alu   = {f7[5], f3};
                dec_legal = (f7 == 7'b0000000) ||
                            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                // FENCE, ECALL and EBREAK move no register data through this stage.
            end
            default: dec_legal = 1'b0;
        endcase
        // An unsupported encoding becomes a NOP. ADDI x0,x0,0 has all fields zero.
        if (!dec_legal) begin
            dec_rs1 = 1'b0;
            dec_rs2 = 1'b0;
            dec_wr  = 1'b0;
            dec_imm = '0;
            dec_alu = '0;
            dec_ctl = '0;
        end
    end

    assign dec_wen = dec_wr & (rd_f != 5'd0);

    // Register-file read ports
    assign rf_rs1   = in_instr[19:15];
    assign rf_rs2   = in_instr[24:20];
    assign rf_r1_en = in_valid & dec_rs1;
    assign rf_r2_en = in_valid & dec_rs2;

    // ID/EX state
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, rs1v_q, rs1v_d, rs2v_q, rs2v_d, imm_q, imm_d;
    logic [4:0]      rd_q, rd_d, ld_rd_q, ld_rd_d;
    logic            wen_q, wen_d;
    logic [3:0]      alu_q, alu_d;
    logic [5:0]      ctl_q, ctl_d;
    logic [1:0]      bub_q, bub_d;
    logic            hazard, accept, load_waiting;

    assign hazard = (bub_q != 2'd0) && (ld_rd_q != 5'd0) &&
                    ((rf_r1_en && (rf_rs1 == ld_rd_q)) || (rf_r2_en && (rf_rs2 == ld_rd_q)));
    assign in_ready = (!valid_q | out_ready) & !hazard & !flush;
    assign accept   = in_valid & in_ready;

    // The bubble window opens when a load is accepted. It stays frozen while
    // that load is stalled in ID/EX. As a result, the LU_BUBS hold cycles always
    // start at the cycle in which the load leaves for execute.
    assign load_waiting = valid_q & ctl_q[5] & !out_ready;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rs1v_d  = rs1v_q;
        rs2v_d  = rs2v_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        wen_d   = wen_q;
        alu_d   = alu_q;
        ctl_d   = ctl_q;
        bub_d   = bub_q;
        ld_rd_d = ld_rd_q;
        if (flush) begin
            valid_d = 1'b0;
            bub_d   = '0;
        end else begin
            if (accept) begin
                valid_d = 1'b1;
                pc_d    = in_pc;
                rs1v_d  = dec_rs1 ? rf_rs1_val : '0;
                rs2v_d  = dec_rs2 ? rf_rs2_val : '0;
                imm_d   = dec_imm;
                rd_d    = dec_wen ? rd_f : 5'd0;
                wen_d   = dec_wen;
                alu_d   = dec_alu;
                ctl_d   = dec_ctl;
            end else if (out_ready) begin
                valid_d = 1'b0;
            end
            if (accept && dec_ctl[5]) begin
                bub_d   = LU_BUBS_C;
                ld_rd_d = dec_wen ? rd_f : 5'd0;
            end else if ((bub_q != 2'd0) && !load_waiting) begin
                bub_d = bub_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1v_q  <= '0;
            rs2v_q  <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            alu_q   <= '0;
            ctl_q   <= '0;
            bub_q   <= '0;
            ld_rd_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1v_q  <= rs1v_d;
            rs2v_q  <= rs2v_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
            alu_q   <= alu_d;
            ctl_q   <= ctl_d;
            bub_q   <= bub_d;
            ld_rd_q <= ld_rd_d;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic ill_q, ill_d;

    always_comb begin
        ill_d = ill_q;
        if (!flush && accept) ill_d = !dec_legal;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ill_q <= 1'b0;
        else      ill_q <= ill_d;
    end

    assign out_illegal = ill_q;
`endif

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_rs1_val = rs1v_q;
    assign out_rs2_val = rs2v_q;
    assign out_imm     = imm_q;
    assign out_rd      = rd_q;
    assign out_rd_wen  = wen_q;
    assign out_alu_op  = alu_q;
    assign out_ctl     = ctl_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Table-driven bench for decode_stage. A table of hand-encoded RV32I
//   instructions carries the expected ID/EX fields for each entry. Short
//   hand-written sequences cover the load-use hold, back-pressure, flush and
//   asynchronous reset.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  rf_rs1, rf_rs2;
    logic        rf_r1_en, rf_r2_en;
    logic [31:0] rf_rs1_val, rf_rs2_val;
    logic        out_valid;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic [3:0]  out_alu_op;
    logic [5:0]  out_ctl;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        out_illegal;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    // Register-file model: x0 = 0, x1 = 7, and xN = 0x1000 + N otherwise.
    function automatic logic [31:0] rfv(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (a == 5'd1) return 32'd7;
        return 32'h1000 + {27'd0, a};
    endfunction

    assign rf_rs1_val = rfv(rf_rs1);
    assign rf_rs2_val = rfv(rf_rs2);

    decode_stage #(.XLEN(32), .LU_BUBS(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .rf_rs1      (rf_rs1),
        .rf_rs2      (rf_rs2),
        .rf_r1_en    (rf_r1_en),
        .rf_r2_en    (rf_r2_en),
        .rf_rs1_val  (rf_rs1_val),
        .rf_rs2_val  (rf_rs2_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val),
        .out_imm     (out_imm),
        .out_rd      (out_rd),
        .out_rd_wen  (out_rd_wen),
        .out_alu_op  (out_alu_op),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .out_illegal (out_illegal),
`endif
        .out_ctl     (out_ctl)
    );

    typedef struct {
        logic [31:0] instr;
        logic        r1en;
        logic        r2en;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wen;
        logic [3:0]  alu;
        logic [5:0]  ctl;
        logic        ill;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        vec_t        v;
        logic [31:0] ins;

        //                 instr         r1    r2    rs1v          rs2v          imm           rd     wen   alu    ctl         ill
        tbl[0]  = '{32'hFFD08293, 1'b1, 1'b0, 32'h00000007, 32'h00000000, 32'hFFFFFFFD, 5'd5, 1'b1, 4'h0, 6'b000000, 1'b0}; // ADDI x5,x1,-3
        tbl[1]  = '{32'h00012183, 1'b1, 1'b0, 32'h00001002, 32'h00000000, 32'h00000000, 5'd3, 1'b1, 4'h0, 6'b100000, 1'b0}; // LW x3,0(x2)
        tbl[2]  = '{32'h00118233, 1'b1, 1'b1, 32'h00001003, 32'h00000007, 32'h00000000, 5'd4, 1'b1, 4'h0, 6'b000000, 1'b0}; // ADD x4,x3,x1
        tbl[3]  = '{32'h40208333, 1'b1, 1'b1, 32'h00000007, 32'h00001002, 32'h00000000, 5'd6, 1'b1, 4'h8, 6'b000000, 1'b0}; // SUB x6,x1,x2
        tbl[4]  = '{32'hFE112E23, 1'b1, 1'b1, 32'h00001002, 32'h00000007, 32'hFFFFFFFC, 5'd0, 1'b0, 4'h0, 6'b010000, 1'b0}; // SW x1,-4(x2)
        tbl[5]  = '{32'hFE208CE3, 1'b1, 1'b1, 32'h00000007, 32'h00001002, 32'hFFFFFFF8, 5'd0, 1'b0, 4'h0, 6'b001000, 1'b0}; // BEQ x1,x2,-8
        tbl[6]  = '{32'h123453B7, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h12345000, 5'd7, 1'b1, 4'h0, 6'b000001, 1'b0}; // LUI x7,0x12345
        tbl[7]  = '{32'h80000417, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h80000000, 5'd8, 1'b1, 4'h0, 6'b000000, 1'b0}; // AUIPC x8,0x80000
        tbl[8]  = '{32'hFFFFF0EF, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 5'd1, 1'b1, 4'h0, 6'b000100, 1'b0}; // JAL x1,-2
        tbl[9]  = '{32'h0010006F, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h00000800, 5'd0, 1'b0, 4'h0, 6'b000100, 1'b0}; // JAL x0,+2048
        tbl[10] = '{32'h00808167, 1'b1, 1'b0, 32'h00000007, 32'h00000000, 32'h00000008, 5'd2, 1'b1, 4'h0, 6'b000010, 1'b0}; // JALR x2,8(x1)
        tbl[11] = '{32'h4030D493, 1'b1, 1'b0, 32'h00000007, 32'h00000000, 32'h00000403, 5'd9, 1'b1, 4'hD, 6'b000000, 1'b0}; // SRAI x9,x1,3
        tbl[12] = '{32'h00000013, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 5'd0, 1'b0, 4'h0, 6'b000000, 1'b0}; // NOP
        tbl[13] = '{32'h00208FFF, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 5'd0, 1'b0, 4'h0, 6'b000000, 1'b1}; // opcode 0x7F
        tbl[14] = '{32'h02208333, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 5'd0, 1'b0, 4'h0, 6'b000000, 1'b1}; // MUL (not RV32I)
        tbl[15] = '{32'h40309493, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 5'd0, 1'b0, 4'h0, 6'b000000, 1'b1}; // SLLI, funct7=0x20

        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_ctl", {26'd0, out_ctl}, 32'd0);
        rst = 1'b1;
        tick;

        // Decode table: accept one instruction, check the fields, then drain.
        for (int i = 0; i < 16; i++) begin
            v   = tbl[i];
            ins = v.instr;
            drive(1'b1, v.instr, 32'h1000 + 32'(i) * 4);
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            chk($sformatf("v%0d_r1_en", i), {31'd0, rf_r1_en}, {31'd0, v.r1en});
            chk($sformatf("v%0d_r2_en", i), {31'd0, rf_r2_en}, {31'd0, v.r2en});
            chk($sformatf("v%0d_rf_rs1", i), {27'd0, rf_rs1}, {27'd0, ins[19:15]});
            tick;
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i) * 4);
            chk($sformatf("v%0d_rs1_val", i), out_rs1_val, v.rs1v);
            chk($sformatf("v%0d_rs2_val", i), out_rs2_val, v.rs2v);
            chk($sformatf("v%0d_imm", i), out_imm, v.imm);
            chk($sformatf("v%0d_rd", i), {27'd0, out_rd}, {27'd0, v.rd});
            chk($sformatf("v%0d_rd_wen", i), {31'd0, out_rd_wen}, {31'd0, v.wen});
            chk($sformatf("v%0d_alu_op", i), {28'd0, out_alu_op}, {28'd0, v.alu});
            chk($sformatf("v%0d_ctl", i), {26'd0, out_ctl}, {26'd0, v.ctl});
`ifdef DECODE_ILLEGAL_TRAP_EN
            chk($sformatf("v%0d_illegal", i), {31'd0, out_illegal}, {31'd0, v.ill});
`endif
            drive(1'b0, 32'h0, 32'h0);
            tick;
        end
        chk("drained_valid", {31'd0, out_valid}, 32'd0);

        // Load-use: LW x3 followed by the dependent ADD x4,x3,x1 is held for one cycle.
        drive(1'b1, 32'h00012183, 32'h3000);
        tick;
        drive(1'b1, 32'h00118233, 32'h3004);
        #1;
        chk("lu_hold_in_ready", {31'd0, in_ready}, 32'd0);
        chk("lu_load_in_idex", {26'd0, out_ctl}, 32'h20);
        tick;
        chk("lu_bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("lu_release_in_ready", {31'd0, in_ready}, 32'd1);
        tick;
        chk("lu_add_valid", {31'd0, out_valid}, 32'd1);
        chk("lu_add_pc", out_pc, 32'h3004);
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) tick;

        // Independent instruction after a load issues back to back.
        drive(1'b1, 32'h00012183, 32'h3100);
        tick;
        drive(1'b1, 32'h00208233, 32'h3104);             // ADD x4,x1,x2
        #1;
        chk("indep_in_ready", {31'd0, in_ready}, 32'd1);
        tick;
        chk("indep_pc", out_pc, 32'h3104);
        chk("indep_rd", {27'd0, out_rd}, 32'd4);
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) tick;

        // Back-pressure: out_ready low for 3 cycles with the next instruction waiting.
        out_ready = 1'b0;
        drive(1'b1, 32'hFFD08293, 32'h4000);
        tick;
        drive(1'b1, 32'h40208333, 32'h4004);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_pc", k), out_pc, 32'h4000);
            chk($sformatf("bp%0d_imm", k), out_imm, 32'hFFFFFFFD);
            tick;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        tick;
        chk("bp_next_pc", out_pc, 32'h4004);
        chk("bp_next_rd", {27'd0, out_rd}, 32'd6);
        drive(1'b0, 32'h0, 32'h0);
        tick;
        chk("bp_single_accept", {31'd0, out_valid}, 32'd0);
        tick;

        // Flush while a load occupies ID/EX and its bubble is armed.
        drive(1'b1, 32'h00012183, 32'h5000);
        tick;
        drive(1'b1, 32'h00118233, 32'h5004);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick;
        flush = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        #1;
        chk("flush_no_bubble", {31'd0, in_ready}, 32'd1);
        tick;
        chk("flush_dep_valid", {31'd0, out_valid}, 32'd1);
        chk("flush_dep_pc", out_pc, 32'h5004);
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) tick;

        // Asynchronous reset in mid-cycle drops the load and its bubble.
        drive(1'b1, 32'h00012183, 32'h6000);
        tick;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        rst = 1'b1;
        drive(1'b1, 32'h00118233, 32'h6004);
        #1;
        chk("arst_no_bubble", {31'd0, in_ready}, 32'd1);
        tick;
        chk("arst_dep_pc", out_pc, 32'h6004);
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
